// File: rtl/video_timing_pkg.sv
// Shared video timing defaults, colour types and helpers for the panel pixel reader.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 48;
    localparam int H_BP_DEF     = 88;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 13;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 32;

    localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

    // 225x225 source image shown 2x in both directions, centred-ish on the panel
    localparam int WIN_X_DEF = 175;
    localparam int WIN_Y_DEF = 15;
    localparam int WIN_W_DEF = 450;
    localparam int WIN_H_DEF = 450;

    typedef logic [15:0] rgb565_t;
    typedef logic [7:0]  gray_t;

    localparam rgb565_t BG_COLOR_DEF = 16'h0000;
    localparam rgb565_t UF_COLOR_DEF = 16'hF800;

    function automatic rgb565_t gray_to_rgb565(input gray_t d);
        return {d[7:3], d[7:2], d[7:3]};
    endfunction

    // Counter width able to hold 0..total inclusive, so end-of-phase bounds fit too.
    function automatic int cnt_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/display_pixel_reader_if.sv
// Pull interface between the pixel loader (master) and the display reader (slave).
interface display_pixel_reader_if;
    import video_timing_pkg::*;

    gray_t i_data;
    logic  i_valid;
    logic  o_next;

    modport master (output i_data, output i_valid, input o_next);
    modport slave  (input i_data, input i_valid, output o_next);

endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with sync-phase flags and active-area coordinates.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HW       = cnt_width(H_SYNC + H_BP + H_ACTIVE + H_FP),
    parameter int VW       = cnt_width(V_SYNC + V_BP + V_ACTIVE + V_FP)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic [HW-1:0] ax,
    output logic [VW-1:0] ay
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_active;
    logic          v_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    assign h_sync   = (h_cnt_reg < H_SYNC_END);
    assign v_sync   = (v_cnt_reg < V_SYNC_END);
    assign h_active = (h_cnt_reg >= H_ACT_START) && (h_cnt_reg < H_ACT_END);
    assign v_active = (v_cnt_reg >= V_ACT_START) && (v_cnt_reg < V_ACT_END);
    assign active   = h_active && v_active;

    // Coordinates wrap outside the active area; consumers only trust them when active.
    assign ax = h_cnt_reg - H_ACT_START;
    assign ay = v_cnt_reg - V_ACT_START;

endmodule

// File: rtl/display_pixel_reader.sv
// Panel timing master that pulls grayscale pixels inside the image window and emits RGB565.
module display_pixel_reader
    import video_timing_pkg::*;
#(
    parameter int      H_ACTIVE = H_ACTIVE_DEF,
    parameter int      H_FP     = H_FP_DEF,
    parameter int      H_SYNC   = H_SYNC_DEF,
    parameter int      H_BP     = H_BP_DEF,
    parameter int      V_ACTIVE = V_ACTIVE_DEF,
    parameter int      V_FP     = V_FP_DEF,
    parameter int      V_SYNC   = V_SYNC_DEF,
    parameter int      V_BP     = V_BP_DEF,
    parameter int      WIN_X    = WIN_X_DEF,
    parameter int      WIN_Y    = WIN_Y_DEF,
    parameter int      WIN_W    = WIN_W_DEF,
    parameter int      WIN_H    = WIN_H_DEF,
    parameter rgb565_t BG_COLOR = BG_COLOR_DEF,
    parameter rgb565_t UF_COLOR = UF_COLOR_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    display_pixel_reader_if.slave  pix,
    output logic                   o_vsync_n,
    output logic                   o_hsync_n,
    output logic                   o_de,
    output rgb565_t                o_rgb,
    output logic                   o_underflow,
    input  logic                   i_clr_underflow
);

    localparam int HW = cnt_width(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam int VW = cnt_width(V_SYNC + V_BP + V_ACTIVE + V_FP);

    localparam logic [HW-1:0] WX_START = HW'(WIN_X);
    localparam logic [HW-1:0] WX_END   = HW'(WIN_X + WIN_W);
    localparam logic [VW-1:0] WY_START = VW'(WIN_Y);
    localparam logic [VW-1:0] WY_END   = VW'(WIN_Y + WIN_H);

    if ((WIN_X + WIN_W > H_ACTIVE) || (WIN_Y + WIN_H > V_ACTIVE)) begin : g_bad_window
        $error("display_pixel_reader: image window exceeds the active area");
    end

    logic          h_sync;
    logic          v_sync;
    logic          active;
    logic [HW-1:0] ax;
    logic [VW-1:0] ay;
    logic          in_win;
    logic          underflow_now;
    rgb565_t       rgb_next;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .active (active),
        .ax     (ax),
        .ay     (ay)
    );

    assign in_win = active
                 && (ax >= WX_START) && (ax < WX_END)
                 && (ay >= WY_START) && (ay < WY_END);

    // Request is held low during reset so the loader never pops while counters are frozen.
    assign pix.o_next    = in_win && rst_n;
    assign underflow_now = in_win && !pix.i_valid;

    always_comb begin
        rgb_next = 16'h0000;
        if (in_win) begin
            rgb_next = pix.i_valid ? gray_to_rgb565(pix.i_data) : UF_COLOR;
        end else if (active) begin
            rgb_next = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync_n   <= 1'b1;
            o_vsync_n   <= 1'b1;
            o_de        <= 1'b0;
            o_rgb       <= 16'h0000;
            o_underflow <= 1'b0;
        end else begin
            o_hsync_n <= !h_sync;
            o_vsync_n <= !v_sync;
            o_de      <= active;
            o_rgb     <= rgb_next;
            // A fresh underflow wins over a simultaneous clear.
            if (underflow_now) begin
                o_underflow <= 1'b1;
            end else if (i_clr_underflow) begin
                o_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_pixel_reader.sv
// Directed + randomized bench for display_pixel_reader on a reduced 22x11 raster.
module tb_display_pixel_reader;
    import video_timing_pkg::*;

    localparam int HA = 16, HF = 2, HS = 2, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 1, VB = 1;
    localparam int WX = 2, WY = 2, WW = 4, WH = 4;
    localparam int H_TOT = HS + HB + HA + HF;
    localparam int V_TOT = VS + VB + VA + VF;
    localparam int FRAME = H_TOT * V_TOT;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    clr;
    logic    vsync_n, hsync_n, de, uf;
    rgb565_t rgb;

    display_pixel_reader_if pix ();

    display_pixel_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .WIN_X (WX), .WIN_Y (WY), .WIN_W (WW), .WIN_H (WH),
        .BG_COLOR (16'h0000), .UF_COLOR (16'hF800)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix             (pix),
        .o_vsync_n       (vsync_n),
        .o_hsync_n       (hsync_n),
        .o_de            (de),
        .o_rgb           (rgb),
        .o_underflow     (uf),
        .i_clr_underflow (clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t;
    int nxt_cnt, hs_cnt, de_cnt;
    bit chk_hs = 0;
    logic exp_uf;
    logic [7:0] tbl [3] = '{8'hFF, 8'h80, 8'h00};

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    function automatic bit win_at(input int tt);
        int h, v, ax, ay;
        h  = tt % H_TOT;
        v  = (tt / H_TOT) % V_TOT;
        ax = h - HS - HB;
        ay = v - VS - VB;
        return (ax >= WX) && (ax < WX + WW) && (ay >= WY) && (ay < WY + WH);
    endfunction

    // Reference values for the three directed grey levels.
    function automatic logic [15:0] tbl_rgb(input logic [7:0] d);
        case (d)
            8'hFF:   return 16'hFFFF;
            8'h80:   return 16'h8410;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] arith_rgb(input logic [7:0] d);
        int r, g;
        r = int'(d) / 8;
        g = int'(d) / 4;
        return 16'(r * 2048 + g * 32 + r);
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic c, input bit use_tbl);
        int h, vv;
        bit hs_e, vs_e, act_e, win_e;
        logic [15:0] rgb_e;
        h     = t % H_TOT;
        vv    = (t / H_TOT) % V_TOT;
        hs_e  = h < HS;
        vs_e  = vv < VS;
        act_e = (h >= HS + HB) && (h < HS + HB + HA) && (vv >= VS + VB) && (vv < VS + VB + VA);
        win_e = win_at(t);
        if (t % FRAME == 0) begin
            nxt_cnt = 0; hs_cnt = 0; de_cnt = 0;
        end
        chk("next", 16'(pix.o_next), 16'(win_e));
        pix.i_valid = v;
        pix.i_data  = d;
        clr         = c;
        if (pix.o_next) nxt_cnt++;
        if (pix.o_next && v) hs_cnt++;
        if (win_e) rgb_e = v ? (use_tbl ? tbl_rgb(d) : arith_rgb(d)) : 16'hF800;
        else       rgb_e = 16'h0000;
        if (win_e && !v) exp_uf = 1'b1;
        else if (c)      exp_uf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t++;
        chk("hsync_n", 16'(hsync_n), 16'(!hs_e));
        chk("vsync_n", 16'(vsync_n), 16'(!vs_e));
        chk("de", 16'(de), 16'(act_e));
        chk("rgb", rgb, rgb_e);
        chk("underflow", 16'(uf), 16'(exp_uf));
        if (de) de_cnt++;
        if (t % FRAME == 0) begin
            chk("next_per_frame", 16'(nxt_cnt), 16'(WW * WH));
            chk("de_per_frame", 16'(de_cnt), 16'(HA * VA));
            if (chk_hs) chk("handshakes", 16'(hs_cnt), 16'(WW * WH));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync_n"}, 16'(hsync_n), 16'h1);
        chk({tag, "_vsync_n"}, 16'(vsync_n), 16'h1);
        chk({tag, "_de"}, 16'(de), 16'h0);
        chk({tag, "_rgb"}, rgb, 16'h0000);
        chk({tag, "_uf"}, 16'(uf), 16'h0);
        chk({tag, "_next"}, 16'(pix.o_next), 16'h0);
    endtask

    initial begin
        bit first;
        bit w;
        rst_n = 1'b0;
        clr = 1'b0;
        pix.i_valid = 1'b0;
        pix.i_data = 8'h00;
        t = 0;
        exp_uf = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Frame 0: directed grey levels, loader always ready.
        for (int k = 0; k < FRAME; k++) step(1'b1, tbl[k % 3], 1'b0, 1'b1);

        // Frame 1: a single starved pixel at the first window position.
        first = 1;
        for (int k = 0; k < FRAME; k++) begin
            w = win_at(t);
            step(!(w && first), 8'($urandom), 1'b0, 1'b0);
            if (w) first = 0;
        end

        // Frame 2: clean frame, sticky flag must persist.
        for (int k = 0; k < FRAME; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);

        // Frame 3: clear coincident with underflow, then a lone clear after the window.
        first = 1;
        for (int k = 0; k < FRAME; k++) begin
            w = win_at(t);
            step(!(w && first), 8'($urandom), (w && first) || (k == 230), 1'b0);
            if (w) first = 0;
        end

        // Frames 4-5: random traffic, async reset in the middle of an active line of frame 5.
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (t == 5 * FRAME + 5 * H_TOT + 10) break;
            step($urandom_range(0, 9) != 0, 8'($urandom), $urandom_range(0, 15) == 0, 1'b0);
        end
        #2 rst_n = 1'b0;
        pix.i_valid = 1'b1;
        #1 chk_reset_vals("midreset");
        @(negedge clk);
        chk_reset_vals("heldreset");
        rst_n = 1'b1;
        t = 0;
        exp_uf = 1'b0;

        // Post-reset: random frame, then a fully fed frame counting handshakes.
        for (int k = 0; k < FRAME; k++)
            step($urandom_range(0, 7) != 0, 8'($urandom), $urandom_range(0, 15) == 0, 1'b0);
        chk_hs = 1;
        for (int k = 0; k < FRAME; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_pixel_reader.md
Name: display_pixel_reader

Overview:
- Consumer end of the loader pull interface (`i_next` / `o_data` / `o_valid`).
- Generates panel video timing and drives the active-low frame sync that the loader uses to flush and restart. It pulls one pixel per clock inside a centred image window and converts 8-bit grayscale to RGB565 for the LCD.
- Sits between the loader and the panel pins. Also flags FIFO underflow.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, hsync pulse width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 32, vertical back porch (lines)
- WIN_X, 175, image window first column (active coordinates)
- WIN_Y, 15, image window first line
- WIN_W, 450, image window width (225 source pixels x 2)
- WIN_H, 450, image window height
- BG_COLOR, 16'h0000, RGB565 outside window
- UF_COLOR, 16'hF800, RGB565 emitted on underflow

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- i_data  in  8  grayscale pixel from loader, valid combinationally in the same cycle
- i_valid  in  1  loader FIFO not empty
- o_next  out  1  pixel request; loader consumes when `o_next && i_valid`
- o_vsync_n  out  1  active-low vsync, to panel and to loader `i_vsync`
- o_hsync_n  out  1  active-low hsync
- o_de  out  1  data enable
- o_rgb  out  16  RGB565 pixel
- o_underflow  out  1  sticky underflow flag
- i_clr_underflow  in  1  synchronous clear of `o_underflow`

Behaviour:
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- Reset values:
  - `h_cnt` = 0, `v_cnt` = 0.
  - `o_hsync_n` = 1, `o_vsync_n` = 1, `o_de` = 0, `o_rgb` = 0, `o_underflow` = 0.
  - `o_next` = 0 (combinational from the counters, but forced 0 while `rst_n` is low).
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
  - Both wrap to 0. Origin is the first clock of the sync pulse.
- Horizontal phases by `h_cnt`:
  - SYNC: [0, H_SYNC)
  - BP: [H_SYNC, H_SYNC+H_BP)
  - ACTIVE: the next H_ACTIVE clocks
  - FP: the remaining clocks
- Vertical phases by `v_cnt` follow the same scheme with the V_* parameters.
- Derived coordinates (combinational):
  - ax = `h_cnt` - H_SYNC - H_BP; ay = `v_cnt` - V_SYNC - V_BP.
  - active = both phases ACTIVE.
  - in_win = active && WIN_X <= ax < WIN_X+WIN_W && WIN_Y <= ay < WIN_Y+WIN_H.
- Request: `o_next` = in_win, combinational. It is asserted regardless of `i_valid`; the loader ignores it when empty.
- Output pipeline: one register stage, so all video outputs appear 1 clock after the counter state that produced them.
  - `o_hsync_n` <= !(h SYNC phase).
  - `o_vsync_n` <= !(v SYNC phase), on every clock of those lines.
  - `o_de` <= active.
  - `o_rgb` <= in_win ? (`i_valid` ? {d[7:3], d[7:2], d[7:3]} : UF_COLOR) : (active ? BG_COLOR : 16'h0000).
- Underflow: set when in_win && !`i_valid`. Set has priority over `i_clr_underflow` in the same cycle. The flag stays set until cleared.
- Frame alignment:
  - The loader is flushed for V_SYNC full lines while `o_vsync_n` is low.
  - The loader refills during V_BP + WIN_Y lines.
  - The loader's 2x horizontal and 2x vertical repeat makes WIN_W x WIN_H requests consume exactly 225x225 source pixels per frame.
  - The reader does not re-index pixels.
- The parameter set must satisfy WIN_X+WIN_W <= H_ACTIVE and WIN_Y+WIN_H <= V_ACTIVE. Check with an elaboration-time assertion.
- Reset mid-frame: counters restart at 0, so vsync asserts on the first post-reset clock and the loader is re-flushed. No partial-frame recovery logic.

Decomposition:
- Package `video_timing_pkg`:
  - H_*/V_* defaults, H_TOTAL/V_TOTAL
  - RGB565 typedef
  - gray-to-RGB565 function
  - window constants
- One sub-module `video_timing_gen` holding the `h_cnt`/`v_cnt` counters and producing phase flags, active, ax and ay.
- The top level adds window compare, request, colour conversion, output register and underflow flag.

Test Plan (small timing for simulation: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=8, V_FP=1, V_SYNC=1, V_BP=1, WIN 4x4 at (2,2)):
- Reset release → first output clock has `o_hsync_n`=0 and `o_vsync_n`=0. The hsync period measures 22 clocks and the vsync period 11 lines; `o_de` is high for 16 clocks per line on 8 lines.
- Window gating → `o_next` high exactly 16 clocks per frame, on active lines 2..5 at columns 2..5. Outside the window with active=1, `o_rgb`=0x0000 (BG).
- Colour conversion → `i_valid`=1 with `i_data`=0xFF gives `o_rgb`=0xFFFF one clock later; 0x80 gives 0x8410; 0x00 gives 0x0000.
- Underflow → hold `i_valid`=0 for one in-window clock: `o_rgb`=0xF800, `o_underflow` goes to 1 and stays set across frames. `i_clr_underflow` clears it; clear coincident with a new underflow leaves it at 1.
- Integration with loader (scaled to a 4x4 source image) → per frame exactly 16 handshakes, no underflow after the first frame, and the pixel sequence equals the expected 2x-replicated source rows.
- Async reset asserted mid-active-line → outputs immediately take their reset values and the counters restart. The next frame is bit-identical to a clean frame.
